// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/HexDriver.sv
// Active-low seven-segment decoder for one hex digit; bit 7 is the unused decimal point.
module HexDriver (
    input  logic [3:0] nibble,
    output logic [7:0] segments
);

    // segment lookup
    always_comb begin
        segments = 8'hFF;
        case (nibble)
            4'h0:    segments = 8'hC0;
            4'h1:    segments = 8'hF9;
            4'h2:    segments = 8'hA4;
            4'h3:    segments = 8'hB0;
            4'h4:    segments = 8'h99;
            4'h5:    segments = 8'h92;
            4'h6:    segments = 8'h82;
            4'h7:    segments = 8'hF8;
            4'h8:    segments = 8'h80;
            4'h9:    segments = 8'h90;
            4'hA:    segments = 8'h88;
            4'hB:    segments = 8'h83;
            4'hC:    segments = 8'hC6;
            4'hD:    segments = 8'hA1;
            4'hE:    segments = 8'h86;
            4'hF:    segments = 8'h8E;
            default: segments = 8'hFF;
        endcase
    end

endmodule

// File: rtl/divider_control.sv
// Sequencing FSM and iteration counter for the divider datapath.
module divider_control
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic Reset_Load_Clear,
    input  logic div_zero,
    input  logic div_ovf,
    output logic load_dividend,
    output logic latch_divisor,
    output logic start_en,
    output logic iter_en,
    output logic fix_en,
    output logic Done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t state, state_n;
    logic [CW-1:0] cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        load_dividend = 1'b0;
        latch_divisor = 1'b0;
        start_en      = 1'b0;
        iter_en       = 1'b0;
        fix_en        = 1'b0;
        case (state)
            IDLE: begin
                if (Reset_Load_Clear) begin
                    load_dividend = 1'b1;
                end else if (Run) begin
                    latch_divisor = 1'b1;
                    state_n       = LOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            LOAD: begin
                start_en = 1'b1;
                // exceptions bypass the iterations entirely
                if (div_zero || div_ovf) begin
                    state_n = DONE;
                end else begin
                    state_n = ITER;
                end
            end
            ITER: begin
                iter_en = 1'b1;
                if (cnt == LAST) begin
                    state_n = FIX;
                end else begin
                    state_n = ITER;
                end
            end
            FIX: begin
                fix_en  = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                if (!Run) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= {CW{1'b0}};
        end else if (start_en) begin
            cnt <= {CW{1'b0}};
        end else if (iter_en) begin
            cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt <= cnt;
        end
    end

    // Done is set one clock into DONE and survives the return to IDLE
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Done <= 1'b0;
        end else if (state == DONE) begin
            Done <= 1'b1;
        end else if (start_en || load_dividend) begin
            Done <= 1'b0;
        end else begin
            Done <= Done;
        end
    end

endmodule

// File: rtl/divider.sv
// Signed restoring divider: magnitudes iterated radix-2, then sign fix-up (truncate toward zero).
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Reset_Load_Clear,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic             Done,
    output logic             DivByZero,
    output logic             Overflow,
    output logic [7:0]       HEX0,
    output logic [7:0]       HEX1,
    output logic [7:0]       HEX2,
    output logic [7:0]       HEX3
);

    logic load_dividend, latch_divisor, start_en, iter_en, fix_en;
    logic div_zero, div_ovf;

    logic [WIDTH-1:0] m_reg, q_work;
    logic [WIDTH:0]   r_work, m_mag;
    logic             sign_q, sign_r;

    logic [WIDTH-1:0] q_abs, m_abs;
    logic [WIDTH:0]   shifted, trial;

    divider_control #(.WIDTH(WIDTH)) u_control (
        .Clk              (Clk),
        .Reset            (Reset),
        .Run              (Run),
        .Reset_Load_Clear (Reset_Load_Clear),
        .div_zero         (div_zero),
        .div_ovf          (div_ovf),
        .load_dividend    (load_dividend),
        .latch_divisor    (latch_divisor),
        .start_en         (start_en),
        .iter_en          (iter_en),
        .fix_en           (fix_en),
        .Done             (Done)
    );

    // an unsigned WIDTH-bit magnitude still holds |most-negative|
    assign q_abs    = Qval[WIDTH-1]  ? (~Qval + {{(WIDTH-1){1'b0}}, 1'b1})  : Qval;
    assign m_abs    = m_reg[WIDTH-1] ? (~m_reg + {{(WIDTH-1){1'b0}}, 1'b1}) : m_reg;
    assign div_zero = (m_reg == {WIDTH{1'b0}});
    assign div_ovf  = (Qval == {1'b1, {(WIDTH-1){1'b0}}}) && (m_reg == {WIDTH{1'b1}});
    assign shifted  = {r_work[WIDTH-1:0], q_work[WIDTH-1]};
    assign trial    = shifted - m_mag;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Qval      <= {WIDTH{1'b0}};
            Rval      <= {WIDTH{1'b0}};
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
            m_reg     <= {WIDTH{1'b0}};
            q_work    <= {WIDTH{1'b0}};
            r_work    <= {(WIDTH+1){1'b0}};
            m_mag     <= {(WIDTH+1){1'b0}};
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
        end else if (load_dividend) begin
            Qval      <= SW;
            Rval      <= {WIDTH{1'b0}};
            DivByZero <= 1'b0;
            Overflow  <= 1'b0;
        end else if (latch_divisor) begin
            m_reg <= SW;
        end else if (start_en) begin
            sign_q    <= Qval[WIDTH-1] ^ m_reg[WIDTH-1];
            sign_r    <= Qval[WIDTH-1];
            q_work    <= q_abs;
            m_mag     <= {1'b0, m_abs};
            r_work    <= {(WIDTH+1){1'b0}};
            DivByZero <= div_zero;
            Overflow  <= div_ovf && !div_zero;
            if (div_zero) begin
                Qval <= {WIDTH{1'b1}};
                Rval <= Qval;
            end else if (div_ovf) begin
                Rval <= {WIDTH{1'b0}};
            end else begin
                Rval <= Rval;
            end
        end else if (iter_en) begin
            // restore by simply not committing a negative trial
            if (!trial[WIDTH]) begin
                r_work <= trial;
                q_work <= {q_work[WIDTH-2:0], 1'b1};
            end else begin
                r_work <= shifted;
                q_work <= {q_work[WIDTH-2:0], 1'b0};
            end
        end else if (fix_en) begin
            Qval <= sign_q ? (~q_work + {{(WIDTH-1){1'b0}}, 1'b1}) : q_work;
            Rval <= sign_r ? (~r_work[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                           : r_work[WIDTH-1:0];
        end else begin
            Qval <= Qval;
        end
    end

    HexDriver u_hex0 (.nibble(Qval[3:0]), .segments(HEX0));
    HexDriver u_hex1 (.nibble(Qval[7:4]), .segments(HEX1));
    HexDriver u_hex2 (.nibble(Rval[3:0]), .segments(HEX2));
    HexDriver u_hex3 (.nibble(Rval[7:4]), .segments(HEX3));

endmodule

// File: tb/tb_divider.sv
// Self-checking bench: directed vector table, corner sequences and a random sweep against a model.
module tb_divider;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic       Reset_Load_Clear = 1'b0;
    logic [7:0] SW = 8'h00;
    logic [7:0] Qval, Rval, HEX0, HEX1, HEX2, HEX3;
    logic       Done, DivByZero, Overflow;

    int checks = 0;
    int errors = 0;

    divider dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Reset_Load_Clear(Reset_Load_Clear),
        .SW(SW), .Qval(Qval), .Rval(Rval), .Done(Done), .DivByZero(DivByZero),
        .Overflow(Overflow), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
        int         lat;
    } vec_t;

    vec_t       vecs[10];
    logic [7:0] seg_tab[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: signed integer division truncating toward zero, plus the exception rules.
    function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic dz, output logic ovf, output int lat);
        int sa, sb, qi, ri;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = 1'b0; ovf = 1'b0; lat = 11;
        if (sb == 0) begin
            q = 8'hFF; r = a; dz = 1'b1; lat = 2;
        end else if (sa == -128 && sb == -1) begin
            q = 8'h80; r = 8'h00; ovf = 1'b1; lat = 2;
        end else begin
            qi = sa / sb;
            ri = sa % sb;
            q = qi[7:0];
            r = ri[7:0];
        end
    endfunction

    task automatic load(input logic [7:0] a);
        @(negedge Clk);
        Reset_Load_Clear = 1'b1;
        SW = a;
        @(negedge Clk);
        Reset_Load_Clear = 1'b0;
    endtask

    // Starts a run with divisor b, scrambles SW after the sample, returns edges until Done.
    task automatic do_run(input logic [7:0] b, input bit drop_run, output int lat);
        @(negedge Clk);
        Run = 1'b1;
        SW = b;
        @(posedge Clk);
        #1 SW = ~b;
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                lat = e;
                break;
            end
        end
        if (drop_run) begin
            @(negedge Clk);
            Run = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                                input logic dz, input logic ovf, input int exp_lat, input int lat);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_qval"}, Qval, q);
        chk({tag, "_rval"}, Rval, r);
        chk({tag, "_divbyzero"}, DivByZero, dz);
        chk({tag, "_overflow"}, Overflow, ovf);
        chk({tag, "_hex0"}, HEX0, seg_tab[q[3:0]]);
        chk({tag, "_hex1"}, HEX1, seg_tab[q[7:4]]);
        chk({tag, "_hex2"}, HEX2, seg_tab[r[3:0]]);
        chk({tag, "_hex3"}, HEX3, seg_tab[r[7:4]]);
    endtask

    initial begin
        int lat;
        logic [7:0] a, b, q, r;
        logic dz, ovf;
        int elat;

        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        vecs[0] = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 11};
        vecs[1] = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 11};
        vecs[2] = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 11};
        vecs[3] = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 11};
        vecs[4] = '{8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1, 1'b0, 2};
        vecs[5] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 2};
        vecs[6] = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 11};
        vecs[7] = '{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 11};
        vecs[8] = '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 11};
        vecs[9] = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 11};

        #12;
        chk("reset_qval", Qval, 8'h00);
        chk("reset_rval", Rval, 8'h00);
        chk("reset_done", Done, 1'b0);
        chk("reset_flags", {DivByZero, Overflow}, 2'b00);
        chk("reset_hex0", HEX0, 8'hC0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            load(vecs[i].a);
            chk("load_qval", Qval, vecs[i].a);
            chk("load_rval", Rval, 8'h00);
            chk("load_done", Done, 1'b0);
            do_run(vecs[i].b, 1'b1, lat);
            check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r,
                         vecs[i].dz, vecs[i].ovf, vecs[i].lat, lat);
            chk("done_held_in_idle", Done, 1'b1);
        end

        // chaining: 100/7 = 14 r 2, then 14/3 = 4 r 2
        load(8'h64);
        do_run(8'h07, 1'b1, lat);
        do_run(8'h03, 1'b0, lat);
        check_result("chain", 8'h04, 8'h02, 1'b0, 1'b0, 11, lat);
        // Run held high in DONE must not restart (a restart would drop Done)
        for (int k = 0; k < 15; k++) begin
            @(negedge Clk);
            chk("run_held_done", Done, 1'b1);
        end
        chk("run_held_qval", Qval, 8'h04);
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);

        // Reset_Load_Clear pulsed mid-iteration is ignored
        load(8'h64);
        @(negedge Clk);
        Run = 1'b1;
        SW = 8'h07;
        repeat (4) @(negedge Clk);
        Run = 1'b0;
        Reset_Load_Clear = 1'b1;
        SW = 8'h55;
        @(negedge Clk);
        Reset_Load_Clear = 1'b0;
        lat = -1;
        for (int e = 0; e < 20; e++) begin
            @(negedge Clk);
            if (Done) begin
                lat = e;
                break;
            end
        end
        chk("rlc_ignored_done_seen", (lat >= 0), 1'b1);
        chk("rlc_ignored_qval", Qval, 8'h0E);
        chk("rlc_ignored_rval", Rval, 8'h02);

        // asynchronous reset in the middle of the iterations
        load(8'h64);
        @(negedge Clk);
        Run = 1'b1;
        SW = 8'h07;
        repeat (6) @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("midreset_qval", Qval, 8'h00);
        chk("midreset_rval", Rval, 8'h00);
        chk("midreset_done", Done, 1'b0);
        chk("midreset_flags", {DivByZero, Overflow}, 2'b00);
        @(negedge Clk);
        Run = 1'b0;
        Reset = 1'b0;
        repeat (14) @(negedge Clk);
        chk("midreset_no_result", {Qval, Rval, Done}, 17'h0);
        load(8'h64);
        do_run(8'h07, 1'b1, lat);
        check_result("after_reset", 8'h0E, 8'h02, 1'b0, 1'b0, 11, lat);

        // random sweep against the reference model
        for (int n = 0; n < 1500; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (n % 50 == 0) b = 8'h00;
            if (n % 77 == 0) begin a = 8'h80; b = 8'hFF; end
            ref_div(a, b, q, r, dz, ovf, elat);
            load(a);
            do_run(b, 1'b1, lat);
            check_result($sformatf("rand_%0h_%0h", a, b), q, r, dz, ovf, elat, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
